// File: rtl/bram_stream_port.sv
// Valid/ready front-end for a single-port block RAM: round-robin merges write and
// read requests, tracks read latency, and returns read data through a credit-limited FIFO.
module bram_stream_port #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  bram_ena,
  output logic                  bram_wea,
  output logic [ADDR_BITS-1:0]  bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  input  logic [DATA_WIDTH-1:0] bram_douta
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                  last_wr;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_ok;
  logic                  wr_gnt;
  logic                  rd_gnt;
  logic [RD_LATENCY-1:0] vld_p;
  logic                  push;
  logic                  pop;
  logic [PTR_W:0]        wptr;
  logic [PTR_W:0]        rptr;
  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];

  // Credits cover both queued responses and reads still inside the BRAM pipeline.
  assign rd_ok = (cnt < CNT_W'(RSP_DEPTH));

  // Each ready is built without its own valid so upstream may wait on it.
  assign wr_ready = !reset && (!(rd_valid && rd_ok) || !last_wr);
  assign rd_ready = !reset && rd_ok && !(wr_valid && !last_wr);
  assign wr_gnt   = wr_valid && wr_ready;
  assign rd_gnt   = rd_valid && rd_ready;

  always_comb begin
    bram_ena   = 1'b0;
    bram_wea   = 1'b0;
    bram_addra = '0;
    bram_dina  = '0;
    if (wr_gnt) begin
      bram_ena   = 1'b1;
      bram_wea   = 1'b1;
      bram_addra = wr_addr;
      bram_dina  = wr_data;
    end else if (rd_gnt) begin
      bram_ena   = 1'b1;
      bram_addra = rd_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_wr <= 1'b0;
    end else if (wr_gnt) begin
      last_wr <= 1'b1;
    end else if (rd_gnt) begin
      last_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({rd_gnt, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Stage boundary: read grant -> BRAM latency tracking, one slot per cycle of delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign push = vld_p[RD_LATENCY-1];

  // Stage boundary: BRAM output -> response FIFO (show-ahead).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[PTR_W-1:0]] <= bram_douta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PTR_W+1)'(1);
      if (pop)  rptr <= rptr + (PTR_W+1)'(1);
    end
  end

  assign rsp_valid = (wptr != rptr);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? mem[rptr[PTR_W-1:0]] : '0;

endmodule
